// File: rtl/snake_pkg.sv
// Shared definitions for the snake segment store: default widths, grid
// limits, initial snake placement and the store's state encoding.
package snake_pkg;

  localparam int X_W_DEF      = 6;
  localparam int Y_W_DEF      = 6;
  localparam int S_ADDR_W_DEF = 6;
  localparam int S_LEN_W_DEF  = 7;

  localparam int GRID_W       = 60;
  localparam int GRID_H       = 44;

  localparam int INIT_LEN_DEF = 3;
  localparam int START_X_DEF  = 10;
  localparam int START_Y_DEF  = 10;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/snake_seg_ram.sv
// Snake body storage: depth x {x,y} register array with one write port and
// two independent registered read ports (self-collision scan, renderer query).
// Reads return the pre-write contents when they hit the address being written.
module snake_seg_ram
  import snake_pkg::*;
#(
  parameter int AW = S_ADDR_W_DEF,
  parameter int DW = X_W_DEF + Y_W_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data,
  input  logic [AW-1:0] query_addr,
  output logic [DW-1:0] query_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Body cell write; contents are rebuilt on every init so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read ports; outputs start at zero out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_data  <= '0;
      query_data <= '0;
    end else begin
      scan_data  <= mem[scan_addr];
      query_data <= mem[query_addr];
    end
  end

endmodule

// File: rtl/snake_segment_store.sv
// Snake body owner: circular buffer of (x,y) cells with head at head_ptr.
// Serves per-pixel segment queries and applies move/grow requests after a
// self-collision scan. Optional macro SEG_STORE_TAIL_OUT_EN adds the
// tail_x_out/tail_y_out/tail_pop_out ports reporting each vacated cell.
module snake_segment_store
  import snake_pkg::*;
#(
  parameter int X        = X_W_DEF,
  parameter int Y        = Y_W_DEF,
  parameter int S_ADDR_W = S_ADDR_W_DEF,
  parameter int S_LEN_W  = S_LEN_W_DEF,
  parameter int INIT_LEN = INIT_LEN_DEF,
  parameter int START_X  = START_X_DEF,
  parameter int START_Y  = START_Y_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear_in,
  input  logic                move_req_in,
  input  logic                grow_in,
  input  logic [X-1:0]        new_head_x_in,
  input  logic [Y-1:0]        new_head_y_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                self_hit_out,
  output logic [S_LEN_W-1:0]  length_out,
  output logic [X-1:0]        head_x_out,
  output logic [Y-1:0]        head_y_out,
  input  logic [S_ADDR_W-1:0] query_addr_in,
  output logic [X-1:0]        query_x_out,
  output logic [Y-1:0]        query_y_out,
  output logic                query_valid_out
`ifdef SEG_STORE_TAIL_OUT_EN
  ,
  output logic [X-1:0]        tail_x_out,
  output logic [Y-1:0]        tail_y_out,
  output logic                tail_pop_out
`endif
);

  localparam logic [S_LEN_W-1:0]  DEPTH      = S_LEN_W'(1 << S_ADDR_W);
  localparam logic [S_LEN_W-1:0]  INIT_LEN_L = S_LEN_W'(INIT_LEN);
  localparam logic [S_LEN_W-1:0]  L_ONE      = 1;
  localparam logic [S_ADDR_W-1:0] A_ONE      = 1;
  localparam logic [X-1:0]        START_X_L  = X'(START_X);
  localparam logic [Y-1:0]        START_Y_L  = Y'(START_Y);

  state_t               state;
  logic [S_LEN_W-1:0]   init_cnt;
  logic [S_ADDR_W-1:0]  head_ptr;
  logic [X-1:0]         cand_x;
  logic [Y-1:0]         cand_y;
  logic                 grow_q;
  logic [S_LEN_W-1:0]   scan_n;
  logic [S_LEN_W-1:0]   issue_idx;
  logic                 rd_vld_p1;

  logic                 wr_en;
  logic [S_ADDR_W-1:0]  wr_addr;
  logic [X+Y-1:0]       wr_data;
  logic [S_ADDR_W-1:0]  scan_addr;
  logic [X+Y-1:0]       scan_data_p1;
  logic [X+Y-1:0]       query_data;
  logic                 issue_last;
  logic                 hit_p1;

  snake_seg_ram #(
    .AW (S_ADDR_W),
    .DW (X + Y)
  ) u_ram (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data_p1),
    .query_addr (head_ptr + query_addr_in),
    .query_data (query_data)
  );

  assign query_x_out = query_data[X+Y-1:Y];
  assign query_y_out = query_data[Y-1:0];

  assign issue_last = (issue_idx == scan_n);
  assign hit_p1     = rd_vld_p1 && (scan_data_p1 == {cand_x, cand_y});

  // Write port: init fills segment i at address i, commit writes the new head.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!clear_in) begin
      if (state == ST_INIT && init_cnt != INIT_LEN_L) begin
        wr_en   = 1'b1;
        wr_addr = init_cnt[S_ADDR_W-1:0];
        wr_data = {START_X_L - X'(init_cnt), START_Y_L};
      end else if (state == ST_COMMIT) begin
        wr_en   = 1'b1;
        wr_addr = head_ptr - A_ONE;
        wr_data = {cand_x, cand_y};
      end
    end
  end

`ifdef SEG_STORE_TAIL_OUT_EN
  logic [S_LEN_W-1:0] len_m1;
  assign len_m1 = length_out - L_ONE;

  // Once the scan has issued its last read, fetch the tail so it is ready in COMMIT.
  always_comb begin
    if (issue_last) scan_addr = head_ptr + len_m1[S_ADDR_W-1:0];
    else            scan_addr = head_ptr + issue_idx[S_ADDR_W-1:0];
  end
`else
  assign scan_addr = head_ptr + issue_idx[S_ADDR_W-1:0];
`endif

  // Latch the proposed head when a move is accepted.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && move_req_in && !clear_in) begin
      cand_x <= new_head_x_in;
      cand_y <= new_head_y_in;
    end
  end

  // Control FSM: init fill, idle, pipelined collision scan, commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      head_ptr     <= '0;
      length_out   <= '0;
      busy_out     <= 1'b1;
      done_out     <= 1'b0;
      self_hit_out <= 1'b0;
      head_x_out   <= '0;
      head_y_out   <= '0;
      grow_q       <= 1'b0;
      scan_n       <= '0;
      issue_idx    <= '0;
      rd_vld_p1    <= 1'b0;
`ifdef SEG_STORE_TAIL_OUT_EN
      tail_x_out   <= '0;
      tail_y_out   <= '0;
      tail_pop_out <= 1'b0;
`endif
    end else if (clear_in) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      head_ptr   <= '0;
      length_out <= '0;
      busy_out   <= 1'b1;
      done_out   <= 1'b0;
      rd_vld_p1  <= 1'b0;
`ifdef SEG_STORE_TAIL_OUT_EN
      tail_pop_out <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
`ifdef SEG_STORE_TAIL_OUT_EN
      tail_pop_out <= 1'b0;
`endif
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_LEN_L) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end else begin
            init_cnt   <= init_cnt + L_ONE;
            length_out <= length_out + L_ONE;
            head_x_out <= START_X_L;
            head_y_out <= START_Y_L;
          end
        end
        ST_IDLE: begin
          if (move_req_in) begin
            grow_q    <= grow_in;
            scan_n    <= grow_in ? length_out : length_out - L_ONE;
            issue_idx <= '0;
            rd_vld_p1 <= 1'b0;
            busy_out  <= 1'b1;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // stage p0: issue next read; stage p1: compare returned cell
          if (!issue_last) issue_idx <= issue_idx + L_ONE;
          rd_vld_p1 <= !issue_last;
          if (hit_p1) begin
            done_out     <= 1'b1;
            self_hit_out <= 1'b1;
            busy_out     <= 1'b0;
            rd_vld_p1    <= 1'b0;
            state        <= ST_IDLE;
          end else if (issue_last && (rd_vld_p1 || scan_n == '0)) begin
            rd_vld_p1 <= 1'b0;
            state     <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          head_ptr   <= head_ptr - A_ONE;
          head_x_out <= cand_x;
          head_y_out <= cand_y;
          if (grow_q && length_out != DEPTH) length_out <= length_out + L_ONE;
          done_out     <= 1'b1;
          self_hit_out <= 1'b0;
          busy_out     <= 1'b0;
          state        <= ST_IDLE;
`ifdef SEG_STORE_TAIL_OUT_EN
          tail_pop_out <= !grow_q || (length_out == DEPTH);
          tail_x_out   <= scan_data_p1[X+Y-1:Y];
          tail_y_out   <= scan_data_p1[Y-1:0];
`endif
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Query valid flag, registered alongside the query read data.
  always_ff @(posedge clk) begin
    if (!reset_n) query_valid_out <= 1'b0;
    else          query_valid_out <= (S_LEN_W'(query_addr_in) < length_out);
  end

endmodule

// File: tb/tb_snake_segment_store.sv
// Directed testbench for snake_segment_store (default parameters).
// Build with SEG_STORE_TAIL_OUT_EN defined to also check the tail outputs.
module tb_snake_segment_store;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear_in = 1'b0;
  logic       move_req_in = 1'b0;
  logic       grow_in = 1'b0;
  logic [5:0] new_head_x_in = '0;
  logic [5:0] new_head_y_in = '0;
  logic       busy_out, done_out, self_hit_out;
  logic [6:0] length_out;
  logic [5:0] head_x_out, head_y_out;
  logic [5:0] query_addr_in = '0;
  logic [5:0] query_x_out, query_y_out;
  logic       query_valid_out;
`ifdef SEG_STORE_TAIL_OUT_EN
  logic [5:0] tail_x_out, tail_y_out;
  logic       tail_pop_out;
`endif

  int total = 0;
  int bad = 0;

  logic       tpop;
  logic [5:0] tx, ty;

  always #5 clk = ~clk;

  snake_segment_store dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clear_in        (clear_in),
    .move_req_in     (move_req_in),
    .grow_in         (grow_in),
    .new_head_x_in   (new_head_x_in),
    .new_head_y_in   (new_head_y_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .self_hit_out    (self_hit_out),
    .length_out      (length_out),
    .head_x_out      (head_x_out),
    .head_y_out      (head_y_out),
    .query_addr_in   (query_addr_in),
    .query_x_out     (query_x_out),
    .query_y_out     (query_y_out),
    .query_valid_out (query_valid_out)
`ifdef SEG_STORE_TAIL_OUT_EN
    ,
    .tail_x_out      (tail_x_out),
    .tail_y_out      (tail_y_out),
    .tail_pop_out    (tail_pop_out)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic query(input logic [5:0] a, input logic [5:0] ex, input logic [5:0] ey,
                       input logic ev, input string tag);
    query_addr_in = a;
    step();
    chk({tag, "_v"}, query_valid_out, ev);
    if (ev) begin
      chk({tag, "_x"}, query_x_out, ex);
      chk({tag, "_y"}, query_y_out, ey);
    end
  endtask

  task automatic do_move(input logic [5:0] x, input logic [5:0] y, input logic g,
                         output int cyc, output logic hit);
    new_head_x_in = x;
    new_head_y_in = y;
    grow_in = g;
    move_req_in = 1'b1;
    step();
    move_req_in = 1'b0;
    grow_in = 1'b0;
    chk("busy_in_move", busy_out, 1);
    cyc = 0;
    while (cyc < 200) begin
      step();
      cyc++;
      if (done_out) break;
    end
    chk("move_done", done_out, 1);
    chk("busy_at_done", busy_out, 0);
    hit = self_hit_out;
`ifdef SEG_STORE_TAIL_OUT_EN
    tpop = tail_pop_out;
    tx = tail_x_out;
    ty = tail_y_out;
`else
    tpop = 1'b0;
    tx = '0;
    ty = '0;
`endif
  endtask

  initial begin
    int         cyc;
    int         n;
    logic       hit;
    logic       saw_done;
    logic [11:0] mdl[$];
    logic [11:0] tail_cell;
    int         L;

    // Reset state
    repeat (3) step();
    chk("rst_busy", busy_out, 1);
    chk("rst_done", done_out, 0);
    chk("rst_hit", self_hit_out, 0);
    chk("rst_len", length_out, 0);
    chk("rst_hx", head_x_out, 0);
    chk("rst_hy", head_y_out, 0);
    chk("rst_qv", query_valid_out, 0);
    chk("rst_qx", query_x_out, 0);
    chk("rst_qy", query_y_out, 0);
`ifdef SEG_STORE_TAIL_OUT_EN
    chk("rst_tpop", tail_pop_out, 0);
    chk("rst_tx", tail_x_out, 0);
    chk("rst_ty", tail_y_out, 0);
`endif

    // Release and init fill
    reset_n = 1'b1;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (!busy_out) break;
    end
    chk("init_cycles", n, 4);
    chk("init_len", length_out, 3);
    chk("init_hx", head_x_out, 10);
    chk("init_hy", head_y_out, 10);
    query(6'd0, 6'd10, 6'd10, 1'b1, "init_q0");
    query(6'd1, 6'd9, 6'd10, 1'b1, "init_q1");
    query(6'd2, 6'd8, 6'd10, 1'b1, "init_q2");
    query(6'd3, 6'd0, 6'd0, 1'b0, "init_q3");

    // Plain move: body (11,10),(10,10),(9,10)
    do_move(6'd11, 6'd10, 1'b0, cyc, hit);
    chk("mv1_cyc", cyc, 4);
    chk("mv1_hit", hit, 0);
    chk("mv1_len", length_out, 3);
    chk("mv1_hx", head_x_out, 11);
`ifdef SEG_STORE_TAIL_OUT_EN
    chk("mv1_tpop", tpop, 1);
    chk("mv1_tx", tx, 8);
    chk("mv1_ty", ty, 10);
`endif
    query(6'd0, 6'd11, 6'd10, 1'b1, "mv1_q0");
    query(6'd2, 6'd9, 6'd10, 1'b1, "mv1_q2");
    query(6'd3, 6'd0, 6'd0, 1'b0, "mv1_q3");

    // Grow: body (12,10),(11,10),(10,10),(9,10)
    do_move(6'd12, 6'd10, 1'b1, cyc, hit);
    chk("gr1_cyc", cyc, 5);
    chk("gr1_hit", hit, 0);
    chk("gr1_len", length_out, 4);
    chk("gr1_hx", head_x_out, 12);
`ifdef SEG_STORE_TAIL_OUT_EN
    chk("gr1_tpop", tpop, 0);
`endif
    query(6'd3, 6'd9, 6'd10, 1'b1, "gr1_q3");

    // Grow to 5: (13,10),(12,10),(11,10),(10,10),(9,10)
    do_move(6'd13, 6'd10, 1'b1, cyc, hit);
    chk("gr2_cyc", cyc, 6);
    chk("gr2_len", length_out, 5);

    // grow_in alone is ignored
    grow_in = 1'b1;
    repeat (3) step();
    grow_in = 1'b0;
    chk("lone_grow_len", length_out, 5);
    chk("lone_grow_busy", busy_out, 0);

    // Self hit on segment 3 (10,10)
    do_move(6'd10, 6'd10, 1'b0, cyc, hit);
    chk("hit_cyc", cyc, 5);
    chk("hit_flag", hit, 1);
    chk("hit_len", length_out, 5);
    chk("hit_hx", head_x_out, 13);
`ifdef SEG_STORE_TAIL_OUT_EN
    chk("hit_tpop", tpop, 0);
`endif
    step();
    chk("hit_hold", self_hit_out, 1);
    chk("hit_done_pulse", done_out, 0);
    query(6'd0, 6'd13, 6'd10, 1'b1, "hit_q0");
    query(6'd3, 6'd10, 6'd10, 1'b1, "hit_q3");
    query(6'd4, 6'd9, 6'd10, 1'b1, "hit_q4");

    // Move onto the vacating tail: (9,10),(13,10),(12,10),(11,10),(10,10)
    do_move(6'd9, 6'd10, 1'b0, cyc, hit);
    chk("tail_cyc", cyc, 6);
    chk("tail_hit", hit, 0);
    chk("tail_len", length_out, 5);
`ifdef SEG_STORE_TAIL_OUT_EN
    chk("tail_tpop", tpop, 1);
    chk("tail_tx", tx, 9);
    chk("tail_ty", ty, 10);
`endif
    query(6'd0, 6'd9, 6'd10, 1'b1, "tail_q0");
    query(6'd1, 6'd13, 6'd10, 1'b1, "tail_q1");
    query(6'd4, 6'd10, 6'd10, 1'b1, "tail_q4");

    // Clear mid-scan with a simultaneous move request
    new_head_x_in = 6'd20;
    new_head_y_in = 6'd20;
    move_req_in = 1'b1;
    step();
    move_req_in = 1'b0;
    repeat (2) step();
    clear_in = 1'b1;
    move_req_in = 1'b1;
    step();
    clear_in = 1'b0;
    move_req_in = 1'b0;
    chk("clr_busy", busy_out, 1);
    chk("clr_len", length_out, 0);
    chk("clr_done", done_out, 0);
    saw_done = 1'b0;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (done_out) saw_done = 1'b1;
      if (!busy_out) break;
    end
    chk("clr_cycles", n, 4);
    chk("clr_no_done", saw_done, 0);
    chk("clr_len3", length_out, 3);
    chk("clr_hx", head_x_out, 10);
    query(6'd0, 6'd10, 6'd10, 1'b1, "clr_q0");
    query(6'd1, 6'd9, 6'd10, 1'b1, "clr_q1");
    query(6'd2, 6'd8, 6'd10, 1'b1, "clr_q2");
    query(6'd3, 6'd0, 6'd0, 1'b0, "clr_q3");

    // Grow 70 times; length saturates at 64
    mdl.delete();
    mdl.push_back({6'd10, 6'd10});
    mdl.push_back({6'd9, 6'd10});
    mdl.push_back({6'd8, 6'd10});
    for (int j = 0; j < 70; j++) begin
      logic [5:0] gx, gy;
      gx = 6'(j % 32);
      gy = 6'(20 + j / 32);
      L = mdl.size();
      tail_cell = mdl[L-1];
      do_move(gx, gy, 1'b1, cyc, hit);
      chk("sat_cyc", cyc, L + 2);
      chk("sat_hit", hit, 0);
      mdl.push_front({gx, gy});
      if (L == 64) void'(mdl.pop_back());
      chk("sat_len", length_out, mdl.size());
`ifdef SEG_STORE_TAIL_OUT_EN
      chk("sat_tpop", tpop, (L == 64));
      if (L == 64) begin
        chk("sat_tx", tx, tail_cell[11:6]);
        chk("sat_ty", ty, tail_cell[5:0]);
      end
`endif
    end
    chk("sat_len64", length_out, 64);
    query(6'd63, 6'd6, 6'd20, 1'b1, "sat_q63");
    query(6'd0, 6'd5, 6'd22, 1'b1, "sat_q0");
    for (int i = 0; i < 64; i++) begin
      query(6'(i), mdl[i][11:6], mdl[i][5:0], 1'b1, "sat_body");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_segment_store.md
Name: snake_segment_store

Overview:
- Responder side of the renderer's segment-query interface: owns the snake body as a circular buffer of (x,y) cells.
- Answers per-pixel index queries from snake_vga_renderer.
- Accepts move/grow requests from the game datapath; checks each proposed new head against the body for self-collision before committing it.
- Sits between the game datapath (move requester) and snake_vga_renderer (query initiator).

Parameters:
- X, 6: x-coordinate width
- Y, 6: y-coordinate width
- S_ADDR_W, 6: buffer address width; depth = 2**S_ADDR_W = 64
- S_LEN_W, 7: length width; must represent 0..2**S_ADDR_W
- INIT_LEN, 3: segments written on init, 1..depth
- START_X, 10: initial head x
- START_Y, 10: initial head y

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- clear_in  in  1  game-reset pulse; re-initialises body
- move_req_in  in  1  request to move; sampled only in IDLE
- grow_in  in  1  qualifies move_req_in: keep tail (length+1)
- new_head_x_in  in  X  proposed head x, sampled with move_req_in
- new_head_y_in  in  Y  proposed head y, sampled with move_req_in
- busy_out  out  1  high outside IDLE
- done_out  out  1  one-cycle pulse ending each move request
- self_hit_out  out  1  valid with done_out; 1 = collision, move discarded
- length_out  out  S_LEN_W  current segment count
- head_x_out  out  X  current head x
- head_y_out  out  Y  current head y
- query_addr_in  in  S_ADDR_W  segment index, 0 = head
- query_x_out  out  X  x of queried segment
- query_y_out  out  Y  y of queried segment
- query_valid_out  out  1  query_addr < length_out

Behaviour:
- Reset: state INIT, init counter 0; busy_out=1, done_out=0, self_hit_out=0, length_out=0, head_x/y_out=0, query_*_out=0, head_ptr=0.
- States: INIT, IDLE, SCAN, COMMIT.
- INIT: one write per cycle; segment i = (START_X-i, START_Y); length_out increments each write; after INIT_LEN writes go to IDLE. head_x/y_out = (START_X, START_Y) from the first write onward.
- IDLE: busy_out=0. On move_req_in, latch new head and grow, go to SCAN.
- SCAN: compare the latched head with segments 0..L-2 when not growing (the tail vacates), or 0..L-1 when growing. One segment per cycle; the registered RAM read adds one pipeline stage.
- SCAN exit:
  - On first match: done_out=1, self_hit_out=1, return to IDLE; buffer untouched.
  - On completion without match: go to COMMIT.
- COMMIT: head_ptr <= head_ptr-1 (mod depth); write new head at the new head_ptr.
  - grow=1 and L<depth: length+1.
  - grow=1 and L=depth: length stays at depth (saturates); oldest cell is overwritten.
  - Then done_out=1, self_hit_out=0; next cycle IDLE.
- Latency: move_req to done is scan count + 2 cycles; worst case depth+2 = 66.
- Query:
  - Physical address = head_ptr + query_addr (mod depth).
  - Outputs registered; 1-cycle latency; served in every state.
  - In the COMMIT cycle the read returns pre-commit contents (read-before-write).
  - query_valid_out compares against the length_out value of the same cycle.
- Ignored inputs: move_req_in outside IDLE; grow_in without move_req_in.
- clear_in (any state, including mid-SCAN): abort; no done_out; length=0; go to INIT. A simultaneous move_req_in is dropped.
- self_hit_out holds its value until the next done_out.
- Coordinates are not range-checked; wall collision belongs upstream.

Optional Feature:
- SEG_STORE_TAIL_OUT_EN defined: adds tail_x_out (X), tail_y_out (Y) and tail_pop_out (1).
  - tail_pop_out pulses in each non-growing COMMIT, and in a saturated grow COMMIT.
  - tail_x_out/tail_y_out carry the vacated cell, letting the renderer erase incrementally.
  - All three are 0 after reset.
- Undefined: ports absent; no extra logic.

Decomposition:
- Package snake_pkg: X/Y/S_ADDR_W/S_LEN_W defaults, grid limits (60x44), INIT_LEN/START_X/START_Y, state enum.
- Sub-module snake_seg_ram: depth x (X+Y) register array; 1 write port, 2 registered read ports (scan, query).

Test Plan:
- Reset, release; wait for busy_out=0 -> 4 cycles after release; length_out=3; queries 0,1,2 return (10,10),(9,10),(8,10) with valid=1; query 3 returns valid=0.
- Move to (11,10), grow=0 -> done_out after 4 cycles, self_hit=0; length=3; query 0 = (11,10); query 2 = (9,10).
- Move (12,10) with grow=1 -> length=4; query 3 = (9,10); head_x_out=12.
- Build length 5, then request head equal to segment 3 -> done_out with self_hit_out=1; length and contents unchanged. Then request head = current tail with grow=0 -> self_hit_out=0 (tail vacates).
- Assert clear_in during SCAN -> no done_out; busy_out stays 1; length returns to 3 with initial coordinates.
- Grow 70 times -> length saturates at 64; query 63 = cell stored 63 moves earlier. With SEG_STORE_TAIL_OUT_EN, tail_pop_out pulses from the 62nd grow onward.
